// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared encodings for the sprite character controller and the
//               reusable sprite streamer: user_input action codes, facing
//               directions, draw FSM states and the default transparent colour.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package sprite_pkg;

  // user_input action codes (6 and 7 decode as "none")
  localparam logic [2:0] IN_NONE   = 3'd0;
  localparam logic [2:0] IN_ATTACK = 3'd1;
  localparam logic [2:0] IN_UP     = 3'd2;
  localparam logic [2:0] IN_DOWN   = 3'd3;
  localparam logic [2:0] IN_LEFT   = 3'd4;
  localparam logic [2:0] IN_RIGHT  = 3'd5;

  // Facing encodings; also the bit index into the blocked vector
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    DRAW_IDLE   = 2'd0,
    DRAW_ACTIVE = 2'd1,
    DRAW_FLUSH  = 2'd2
  } draw_state_e;

  localparam logic [5:0] TRANSPARENT_DEFAULT = 6'h3F;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_streamer
// Description : Streams one SPRITE_W x SPRITE_H sprite from a synchronous ROM.
//               Scans px/py, drives the ROM address from the pose latched at
//               draw start, and registers the screen coordinates alongside the
//               ROM's own output register so x/y/colour line up.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               abort             - drop any draw in progress, no done pulse
//               draw_start        - request a draw (ignored while busy)
//               pose              - sprite pose index, latched on start
//               x_base, y_base    - sprite top-left on screen
//               sprite_addr       - ROM address (combinational)
//               sprite_data       - ROM output, one cycle after the address
//               x_draw, y_draw    - pixel coordinate aligned with pixel_color
//               pixel_color       - ROM colour during valid pixels, else 0
//               vga_write         - valid pixel that is not transparent
//               draw_busy         - draw in progress
//               draw_done         - one-cycle pulse after the last pixel
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_streamer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W                  = 16,
  parameter int SPRITE_H                  = 16,
  parameter int X_W                       = 9,
  parameter int Y_W                       = 8,
  parameter int COLOR_W                   = 6,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(TRANSPARENT_DEFAULT),
  parameter int ADDR_W                    = 13,
  parameter int POSE_W                    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               abort,
  input  logic               draw_start,
  input  logic [POSE_W-1:0]  pose,
  input  logic [X_W-1:0]     x_base,
  input  logic [Y_W-1:0]     y_base,
  output logic [ADDR_W-1:0]  sprite_addr,
  input  logic [COLOR_W-1:0] sprite_data,
  output logic [X_W-1:0]     x_draw,
  output logic [Y_W-1:0]     y_draw,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               vga_write,
  output logic               draw_busy,
  output logic               draw_done
);

  localparam int PX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int PY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(SPRITE_W - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(SPRITE_H - 1);

  draw_state_e        state_q, state_d;
  logic [PX_W-1:0]    px_q, px_d;
  logic [PY_W-1:0]    py_q, py_d;
  logic [POSE_W-1:0]  pose_q, pose_d;
  logic               valid_q, valid_d;
  logic [X_W-1:0]     x_draw_q, x_draw_d;
  logic [Y_W-1:0]     y_draw_q, y_draw_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    pose_d   = pose_q;
    valid_d  = 1'b0;
    x_draw_d = '0;
    y_draw_d = '0;
    done_d   = 1'b0;

    if (abort) begin
      state_d = DRAW_IDLE;
      px_d    = '0;
      py_d    = '0;
    end else begin
      case (state_q)
        DRAW_IDLE: begin
          if (draw_start) begin
            state_d = DRAW_ACTIVE;
            px_d    = '0;
            py_d    = '0;
            pose_d  = pose;
          end
        end
        DRAW_ACTIVE: begin
          // Coordinates are captured on the same edge the ROM captures the
          // address, so they emerge together with sprite_data.
          valid_d  = 1'b1;
          x_draw_d = x_base + X_W'(px_q);
          y_draw_d = y_base + Y_W'(py_q);
          if (px_q == PX_LAST) begin
            px_d = '0;
            if (py_q == PY_LAST) begin
              state_d = DRAW_FLUSH;
            end else begin
              py_d = py_q + PY_W'(1);
            end
          end else begin
            px_d = px_q + PX_W'(1);
          end
        end
        DRAW_FLUSH: begin
          state_d = DRAW_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = DRAW_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= DRAW_IDLE;
      px_q     <= '0;
      py_q     <= '0;
      pose_q   <= '0;
      valid_q  <= 1'b0;
      x_draw_q <= '0;
      y_draw_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pose_q   <= pose_d;
      valid_q  <= valid_d;
      x_draw_q <= x_draw_d;
      y_draw_q <= y_draw_d;
      done_q   <= done_d;
    end
  end

  // Power-of-two sprite sizes make pose*W*H + py*W + px a plain concatenation.
  assign sprite_addr = ADDR_W'({pose_q, py_q, px_q});

  // The ROM output register is the colour stage; gate it so idle reads as 0.
  assign pixel_color = valid_q ? sprite_data : '0;
  assign vga_write   = valid_q && (sprite_data != TRANSPARENT);
  assign x_draw      = x_draw_q;
  assign y_draw      = y_draw_q;
  assign draw_busy   = (state_q != DRAW_IDLE);
  assign draw_done   = done_q;

endmodule : sprite_streamer
`default_nettype wire

// File: rtl/sprite_char_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_char_ctrl
// Description : Player/NPC character controller. Keeps position, facing,
//               attack state and walk animation, applies per-direction blocking
//               and map-edge clamping on each action tick, and streams the
//               current pose from the sprite ROM through sprite_streamer.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               init              - reload start position, abort any draw
//               apply_action      - action tick, honoured only when not drawing
//               user_input        - action code (see sprite_pkg)
//               blocked           - [0] up, [1] down, [2] left, [3] right
//               draw_start        - request to stream the sprite
//               sprite_addr/data  - synchronous sprite ROM interface
//               x_pos, y_pos      - sprite top-left
//               facing, attacking - current pose state
//               x_draw, y_draw, pixel_color, vga_write - pixel stream
//               draw_busy, draw_done - draw status
// Revision    : 1.0 - parametrised successor to the fixed 16x16 controller
// ============================================================================
module sprite_char_ctrl
  import sprite_pkg::*;
#(
  parameter int SPRITE_W                    = 16,
  parameter int SPRITE_H                    = 16,
  parameter int MAP_W                       = 256,
  parameter int MAP_H                       = 176,
  parameter int X_W                         = 9,
  parameter int Y_W                         = 8,
  parameter int INIT_X                      = 127,
  parameter int INIT_Y                      = 88,
  parameter int STEP                        = 1,
  parameter int FRAMES                      = 2,
  parameter int ANIM_DIV                    = 8,
  parameter int ATTACK_LEN                  = 4,
  parameter int COLOR_W                     = 6,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(TRANSPARENT_DEFAULT),
  parameter int ADDR_W                      = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               apply_action,
  input  logic [2:0]         user_input,
  input  logic [3:0]         blocked,
  input  logic               draw_start,
  output logic [ADDR_W-1:0]  sprite_addr,
  input  logic [COLOR_W-1:0] sprite_data,
  output logic [X_W-1:0]     x_pos,
  output logic [Y_W-1:0]     y_pos,
  output logic [1:0]         facing,
  output logic               attacking,
  output logic [X_W-1:0]     x_draw,
  output logic [Y_W-1:0]     y_draw,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               vga_write,
  output logic               draw_busy,
  output logic               draw_done
);

  localparam int POSE_W  = $clog2(4 * FRAMES + 4);
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int ATK_W   = (ATTACK_LEN > 1) ? $clog2(ATTACK_LEN) : 1;

  localparam logic [X_W-1:0]     X_MAX      = X_W'(MAP_W - SPRITE_W);
  localparam logic [Y_W-1:0]     Y_MAX      = Y_W'(MAP_H - SPRITE_H);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ANIM_DIV - 1);

  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [1:0]         facing_q, facing_d;
  logic               attacking_q, attacking_d;
  logic [ATK_W-1:0]   atk_cnt_q, atk_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   move_cnt_q, move_cnt_d;

  logic               w_is_move;
  logic [1:0]         w_dir;
  logic               w_at_edge;
  logic               w_accept;
  logic [X_W-1:0]     w_x_inc, w_x_dec;
  logic [Y_W-1:0]     w_y_inc, w_y_dec;
  logic [POSE_W-1:0]  w_pose;
  logic               w_busy;

  // Decode the movement request into a direction
  always_comb begin
    w_is_move = 1'b1;
    w_dir     = DIR_DOWN;
    case (user_input)
      IN_UP:    w_dir = DIR_UP;
      IN_DOWN:  w_dir = DIR_DOWN;
      IN_LEFT:  w_dir = DIR_LEFT;
      IN_RIGHT: w_dir = DIR_RIGHT;
      default:  w_is_move = 1'b0;
    endcase
  end

  // Stepped positions, clamped to the playable area
  assign w_x_inc = (({1'b0, x_q} + (X_W+1)'(STEP)) > {1'b0, X_MAX}) ? X_MAX : x_q + X_W'(STEP);
  assign w_x_dec = (x_q < X_W'(STEP)) ? '0 : x_q - X_W'(STEP);
  assign w_y_inc = (({1'b0, y_q} + (Y_W+1)'(STEP)) > {1'b0, Y_MAX}) ? Y_MAX : y_q + Y_W'(STEP);
  assign w_y_dec = (y_q < Y_W'(STEP)) ? '0 : y_q - Y_W'(STEP);

  // Already sitting on the clamp is treated exactly like a blocked direction
  always_comb begin
    w_at_edge = 1'b0;
    case (w_dir)
      DIR_UP:    w_at_edge = (y_q == '0);
      DIR_DOWN:  w_at_edge = (y_q >= Y_MAX);
      DIR_LEFT:  w_at_edge = (x_q == '0);
      default:   w_at_edge = (x_q >= X_MAX);
    endcase
  end

  assign w_accept = w_is_move && !blocked[w_dir] && !w_at_edge;

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    facing_d    = facing_q;
    attacking_d = attacking_q;
    atk_cnt_d   = atk_cnt_q;
    frame_d     = frame_q;
    move_cnt_d  = move_cnt_q;

    if (init) begin
      x_d         = X_W'(INIT_X);
      y_d         = Y_W'(INIT_Y);
      facing_d    = DIR_DOWN;
      attacking_d = 1'b0;
      atk_cnt_d   = '0;
      frame_d     = '0;
      move_cnt_d  = '0;
    end else if (apply_action && !w_busy) begin
      if (attacking_q) begin
        // Every tick of an attack counts down; the pose is frozen meanwhile.
        attacking_d = (atk_cnt_q > ATK_W'(1));
        atk_cnt_d   = (atk_cnt_q == '0) ? '0 : atk_cnt_q - ATK_W'(1);
      end else if (user_input == IN_ATTACK) begin
        attacking_d = 1'b1;
        atk_cnt_d   = ATK_W'(ATTACK_LEN - 1);
      end else if (w_is_move) begin
        facing_d = w_dir;
        if (w_accept) begin
          case (w_dir)
            DIR_UP:   y_d = w_y_dec;
            DIR_DOWN: y_d = w_y_inc;
            DIR_LEFT: x_d = w_x_dec;
            default:  x_d = w_x_inc;
          endcase
          if (move_cnt_q == CNT_LAST) begin
            move_cnt_d = '0;
            frame_d    = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
          end else begin
            move_cnt_d = move_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      facing_q    <= DIR_DOWN;
      attacking_q <= 1'b0;
      atk_cnt_q   <= '0;
      frame_q     <= '0;
      move_cnt_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      facing_q    <= facing_d;
      attacking_q <= attacking_d;
      atk_cnt_q   <= atk_cnt_d;
      frame_q     <= frame_d;
      move_cnt_q  <= move_cnt_d;
    end
  end

  // Walk poses are grouped by facing; the four attack poses follow them.
  assign w_pose = attacking_q ? (POSE_W'(4 * FRAMES) + POSE_W'(facing_q))
                              : (POSE_W'(facing_q) * POSE_W'(FRAMES) + POSE_W'(frame_q));

  sprite_streamer #(
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H),
    .X_W         (X_W),
    .Y_W         (Y_W),
    .COLOR_W     (COLOR_W),
    .TRANSPARENT (TRANSPARENT),
    .ADDR_W      (ADDR_W),
    .POSE_W      (POSE_W)
  ) u_streamer (
    .clock       (clock),
    .reset       (reset),
    .abort       (init),
    .draw_start  (draw_start),
    .pose        (w_pose),
    .x_base      (x_q),
    .y_base      (y_q),
    .sprite_addr (sprite_addr),
    .sprite_data (sprite_data),
    .x_draw      (x_draw),
    .y_draw      (y_draw),
    .pixel_color (pixel_color),
    .vga_write   (vga_write),
    .draw_busy   (w_busy),
    .draw_done   (draw_done)
  );

  assign draw_busy = w_busy;
  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign facing    = facing_q;
  assign attacking = attacking_q;

endmodule : sprite_char_ctrl
`default_nettype wire

// File: tb/tb_sprite_char_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_char_ctrl
// Description : Directed self-checking bench for sprite_char_ctrl with a
//               behavioural synchronous sprite ROM (odd px -> 6'h05, even px
//               -> transparent 6'h3F).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_char_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        init;
  logic        apply_action;
  logic [2:0]  user_input;
  logic [3:0]  blocked;
  logic        draw_start;
  logic [12:0] sprite_addr;
  logic [5:0]  sprite_data = 6'h00;
  logic [8:0]  x_pos;
  logic [7:0]  y_pos;
  logic [1:0]  facing;
  logic        attacking;
  logic [8:0]  x_draw;
  logic [7:0]  y_draw;
  logic [5:0]  pixel_color;
  logic        vga_write;
  logic        draw_busy;
  logic        draw_done;

  int n_vec = 0;
  int n_bad = 0;

  sprite_char_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .init         (init),
    .apply_action (apply_action),
    .user_input   (user_input),
    .blocked      (blocked),
    .draw_start   (draw_start),
    .sprite_addr  (sprite_addr),
    .sprite_data  (sprite_data),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .facing       (facing),
    .attacking    (attacking),
    .x_draw       (x_draw),
    .y_draw       (y_draw),
    .pixel_color  (pixel_color),
    .vga_write    (vga_write),
    .draw_busy    (draw_busy),
    .draw_done    (draw_done)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: address bit 0 is px bit 0
  always @(posedge clock) sprite_data <= sprite_addr[0] ? 6'h05 : 6'h3F;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic act(input logic [2:0] code, input logic [3:0] blk);
    apply_action = 1'b1;
    user_input   = code;
    blocked      = blk;
    tick();
    apply_action = 1'b0;
    user_input   = 3'd0;
    blocked      = 4'd0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!draw_done && cyc < 400) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (draw_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: draw_done got %b required 1 within 400 cycles", name, draw_done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; init = 1'b0; apply_action = 1'b0; user_input = 3'd0;
    blocked = 4'd0; draw_start = 1'b0;
    tick(); tick();
    n_vec++; if (x_pos !== 9'd0) begin n_bad++; $display("FAIL reset_x: got %0d required 0", x_pos); end
    n_vec++; if (y_pos !== 8'd0) begin n_bad++; $display("FAIL reset_y: got %0d required 0", y_pos); end
    n_vec++; if (facing !== 2'd1) begin n_bad++; $display("FAIL reset_facing: got %0d required 1", facing); end
    n_vec++; if (attacking !== 1'b0) begin n_bad++; $display("FAIL reset_attacking: got %b required 0", attacking); end
    n_vec++; if ({draw_busy, draw_done, vga_write} !== 3'b000) begin
      n_bad++; $display("FAIL reset_draw_flags: got %b required 000", {draw_busy, draw_done, vga_write});
    end
    n_vec++; if ({x_draw, y_draw, pixel_color} !== 23'd0) begin
      n_bad++; $display("FAIL reset_draw_data: got %h required 0", {x_draw, y_draw, pixel_color});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_init;
    init = 1'b1;
    tick();
    init = 1'b0;
    n_vec++; if (x_pos !== 9'd127) begin n_bad++; $display("FAIL init_x: got %0d required 127", x_pos); end
    n_vec++; if (y_pos !== 8'd88) begin n_bad++; $display("FAIL init_y: got %0d required 88", y_pos); end
    n_vec++; if (facing !== 2'd1) begin n_bad++; $display("FAIL init_facing: got %0d required 1", facing); end
    n_vec++; if (attacking !== 1'b0) begin n_bad++; $display("FAIL init_attacking: got %b required 0", attacking); end
    n_vec++; if (draw_busy !== 1'b0) begin n_bad++; $display("FAIL init_busy: got %b required 0", draw_busy); end
  endtask

  task automatic test_move_anim;
    repeat (8) act(3'd5, 4'd0);
    n_vec++; if (x_pos !== 9'd135) begin n_bad++; $display("FAIL move8_x: got %0d required 135", x_pos); end
    n_vec++; if (y_pos !== 8'd88) begin n_bad++; $display("FAIL move8_y: got %0d required 88", y_pos); end
    n_vec++; if (facing !== 2'd3) begin n_bad++; $display("FAIL move8_facing: got %0d required 3", facing); end
  endtask

  // Pose right/frame 1 = 7, so the ROM base is 7*256 = 1792; sprite at (135,88)
  task automatic test_draw;
    int         wr_cnt = 0;
    int         k;
    logic [12:0] exp_addr;
    logic [8:0]  exp_x;
    logic [7:0]  exp_y;
    logic [5:0]  exp_col;
    logic        exp_busy, exp_done, exp_wr;
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    for (int c = 1; c <= 259; c++) begin
      if (c <= 256) begin
        exp_addr = 13'(1792 + c - 1);
        n_vec++; if (sprite_addr !== exp_addr) begin
          n_bad++; $display("FAIL draw_addr c%0d: got %0d required %0d", c, sprite_addr, exp_addr);
        end
      end
      exp_busy = (c <= 257);
      exp_done = (c == 258);
      n_vec++; if ({draw_busy, draw_done} !== {exp_busy, exp_done}) begin
        n_bad++; $display("FAIL draw_status c%0d: busy/done got %b%b required %b%b", c, draw_busy, draw_done, exp_busy, exp_done);
      end
      if (c >= 2 && c <= 257) begin
        k       = c - 2;
        exp_x   = 9'(135 + (k % 16));
        exp_y   = 8'(88 + (k / 16));
        exp_wr  = (k % 2) == 1;
        exp_col = exp_wr ? 6'h05 : 6'h3F;
        n_vec++; if ({x_draw, y_draw} !== {exp_x, exp_y}) begin
          n_bad++; $display("FAIL draw_xy pix%0d: got (%0d,%0d) required (%0d,%0d)", k, x_draw, y_draw, exp_x, exp_y);
        end
        n_vec++; if ({vga_write, pixel_color} !== {exp_wr, exp_col}) begin
          n_bad++; $display("FAIL draw_pix pix%0d: wr/col got %b/%h required %b/%h", k, vga_write, pixel_color, exp_wr, exp_col);
        end
      end else begin
        n_vec++; if (vga_write !== 1'b0) begin
          n_bad++; $display("FAIL draw_idle_wr c%0d: got %b required 0", c, vga_write);
        end
      end
      if (vga_write === 1'b1) wr_cnt++;
      // Action and a second start during the draw must both be ignored
      apply_action = (c == 50);
      user_input   = (c == 50) ? 3'd5 : 3'd0;
      draw_start   = (c == 60);
      tick();
    end
    apply_action = 1'b0; user_input = 3'd0; draw_start = 1'b0;
    n_vec++; if (wr_cnt != 128) begin n_bad++; $display("FAIL draw_wr_count: got %0d required 128", wr_cnt); end
    n_vec++; if (x_pos !== 9'd135) begin n_bad++; $display("FAIL draw_ignore_action: x got %0d required 135", x_pos); end
  endtask

  task automatic test_blocked;
    act(3'd2, 4'b0001);
    n_vec++; if ({y_pos, facing} !== {8'd88, 2'd0}) begin
      n_bad++; $display("FAIL blk_up: y/facing got %0d/%0d required 88/0", y_pos, facing);
    end
    act(3'd4, 4'b0100);
    n_vec++; if ({x_pos, facing} !== {9'd135, 2'd2}) begin
      n_bad++; $display("FAIL blk_left: x/facing got %0d/%0d required 135/2", x_pos, facing);
    end
    act(3'd3, 4'b0001);
    n_vec++; if ({y_pos, facing} !== {8'd89, 2'd1}) begin
      n_bad++; $display("FAIL down_other_blk: y/facing got %0d/%0d required 89/1", y_pos, facing);
    end
  endtask

  task automatic test_edges;
    repeat (89) act(3'd2, 4'd0);
    n_vec++; if (y_pos !== 8'd0) begin n_bad++; $display("FAIL edge_reach_top: got %0d required 0", y_pos); end
    act(3'd2, 4'd0);
    n_vec++; if ({y_pos, facing} !== {8'd0, 2'd0}) begin
      n_bad++; $display("FAIL edge_top_clamp: y/facing got %0d/%0d required 0/0", y_pos, facing);
    end
    repeat (105) act(3'd5, 4'd0);
    n_vec++; if (x_pos !== 9'd240) begin n_bad++; $display("FAIL edge_reach_right: got %0d required 240", x_pos); end
    act(3'd5, 4'd0);
    n_vec++; if ({x_pos, facing} !== {9'd240, 2'd3}) begin
      n_bad++; $display("FAIL edge_right_clamp: x/facing got %0d/%0d required 240/3", x_pos, facing);
    end
    act(3'd4, 4'd0);
    n_vec++; if (x_pos !== 9'd239) begin n_bad++; $display("FAIL edge_leave_right: got %0d required 239", x_pos); end
  endtask

  // Facing left (2), at (239,0)
  task automatic test_attack;
    act(3'd1, 4'd0);
    n_vec++; if (attacking !== 1'b1) begin n_bad++; $display("FAIL atk_tick1: got %b required 1", attacking); end
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    n_vec++; if (sprite_addr !== 13'd2560) begin
      n_bad++; $display("FAIL atk_pose_addr: got %0d required 2560", sprite_addr);
    end
    wait_done("atk_draw_done");
    tick();
    act(3'd5, 4'd0);
    n_vec++; if ({attacking, x_pos, y_pos} !== {1'b1, 9'd239, 8'd0}) begin
      n_bad++; $display("FAIL atk_tick2: atk/x/y got %b/%0d/%0d required 1/239/0", attacking, x_pos, y_pos);
    end
    act(3'd1, 4'd0);
    n_vec++; if (attacking !== 1'b1) begin n_bad++; $display("FAIL atk_tick3: got %b required 1", attacking); end
    act(3'd4, 4'd0);
    n_vec++; if ({attacking, x_pos, y_pos} !== {1'b0, 9'd239, 8'd0}) begin
      n_bad++; $display("FAIL atk_tick4: atk/x/y got %b/%0d/%0d required 0/239/0", attacking, x_pos, y_pos);
    end
    act(3'd5, 4'd0);
    n_vec++; if (x_pos !== 9'd240) begin n_bad++; $display("FAIL atk_after_move: got %0d required 240", x_pos); end
  endtask

  task automatic test_init_abort;
    logic saw_done = 1'b0;
    logic saw_wr   = 1'b0;
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    repeat (99) tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    n_vec++; if ({draw_busy, vga_write} !== 2'b00) begin
      n_bad++; $display("FAIL abort_flags: busy/wr got %b%b required 00", draw_busy, vga_write);
    end
    n_vec++; if ({x_pos, y_pos, facing} !== {9'd127, 8'd88, 2'd1}) begin
      n_bad++; $display("FAIL abort_pos: x/y/f got %0d/%0d/%0d required 127/88/1", x_pos, y_pos, facing);
    end
    repeat (300) begin
      tick();
      if (draw_done === 1'b1) saw_done = 1'b1;
      if (vga_write === 1'b1) saw_wr = 1'b1;
    end
    n_vec++; if ({saw_done, saw_wr} !== 2'b00) begin
      n_bad++; $display("FAIL abort_quiet: done/wr seen %b%b required 00", saw_done, saw_wr);
    end
    // Fresh draw after init: facing down, frame cleared -> pose 2
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    n_vec++; if (sprite_addr !== 13'd512) begin
      n_bad++; $display("FAIL init_pose_addr: got %0d required 512", sprite_addr);
    end
    wait_done("post_init_draw_done");
  endtask

  initial begin
    test_reset();
    test_init();
    test_move_anim();
    test_draw();
    test_blocked();
    test_edges();
    test_attack();
    test_init_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_sprite_char_ctrl
`default_nettype wire
